// File: rtl/dual_adc_capture.sv
// Dual 10-bit ADC capture: level/forced trigger, pre/post-trigger ring buffer, valid/ready readout.
// Optional macro ADC_OTR_STORE_EN stores the OTR flags alongside each sample.
module dual_adc_capture #(
  parameter int unsigned DATA_W   = 10,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned PRE_TRIG = 256
) (
  input  logic              clk_20M,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] ad_data1,
  input  logic [DATA_W-1:0] ad_data2,
  input  logic              OTR1,
  input  logic              OTR2,
  input  logic              arm,
  input  logic              abort,
  input  logic              force_trig,
  input  logic              trig_ch,
  input  logic              trig_edge,
  input  logic [DATA_W-1:0] trig_level,
  output logic              busy,
  output logic              done,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_last,
  output logic              rd_otr1,
  output logic              rd_otr2
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned POST_N = DEPTH - PRE_TRIG - 1;
`ifdef ADC_OTR_STORE_EN
  localparam int unsigned RAM_W  = 2 * DATA_W + 2;
`else
  localparam int unsigned RAM_W  = 2 * DATA_W;
`endif
  localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE_TRIG);
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_TRIG - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(POST_N - 1);
  localparam logic [ADDR_W:0]   WORDS     = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   LAST_WORD = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, READ} state_t;

  state_t              state;
  logic [DATA_W-1:0]   s1_d1, s1_d2, prv_d1, prv_d2;
  logic [ADDR_W-1:0]   wp, rp, t_ptr, cnt;
  logic [ADDR_W:0]     iss_cnt;
  logic                a_vld, a_last;
  logic [RAM_W-1:0]    mem [DEPTH];
  logic [RAM_W-1:0]    ram_q;
  logic [RAM_W-1:0]    wdata;
  logic [DATA_W-1:0]   cur, prv;
  logic                trig, we, re, move, fire;

  // Single input register stage; prv holds the previous registered sample for edge detection.
  always_ff @(posedge clk_20M) begin
    if (!rst_n) begin
      s1_d1  <= '0;
      s1_d2  <= '0;
      prv_d1 <= '0;
      prv_d2 <= '0;
    end else begin
      s1_d1  <= ad_data1;
      s1_d2  <= ad_data2;
      prv_d1 <= s1_d1;
      prv_d2 <= s1_d2;
    end
  end

`ifdef ADC_OTR_STORE_EN
  logic s1_o1, s1_o2;

  always_ff @(posedge clk_20M) begin
    if (!rst_n) begin
      s1_o1 <= 1'b0;
      s1_o2 <= 1'b0;
    end else begin
      s1_o1 <= OTR1;
      s1_o2 <= OTR2;
    end
  end

  assign wdata = {s1_o2, s1_o1, s1_d2, s1_d1};
`else
  logic unused_otr;
  assign unused_otr = OTR1 ^ OTR2;
  assign wdata      = {s1_d2, s1_d1};
`endif

  // Level-crossing trigger on the selected channel, OR'd with the software trigger.
  always_comb begin
    cur = s1_d1;
    prv = prv_d1;
    if (trig_ch) begin
      cur = s1_d2;
      prv = prv_d2;
    end
    if (trig_edge) trig = (prv >= trig_level) && (cur < trig_level);
    else           trig = (prv < trig_level) && (cur >= trig_level);
    trig = trig || force_trig;
  end

  // Readout is a two-stage pipeline: RAM output register (a_vld) feeding the output register.
  assign we   = (state == PRE) || (state == ARMED) || (state == POST);
  assign move = a_vld && (!rd_valid || rd_ready);
  assign fire = rd_valid && rd_ready;
  assign re   = (state == READ) && !abort && (iss_cnt != WORDS) && (!a_vld || move);

  // Ring buffer; the read port register holds its value while the pipeline is stalled.
  always_ff @(posedge clk_20M) begin
    if (we) mem[wp] <= wdata;
    if (re) ram_q <= mem[rp];
  end

  always_ff @(posedge clk_20M) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_data1 <= '0;
      rd_data2 <= '0;
      rd_otr1  <= 1'b0;
      rd_otr2  <= 1'b0;
      wp       <= '0;
      rp       <= '0;
      t_ptr    <= '0;
      cnt      <= '0;
      iss_cnt  <= '0;
      a_vld    <= 1'b0;
      a_last   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (we) wp <= wp + 1'b1;
      if (abort) begin
        state    <= IDLE;
        busy     <= 1'b0;
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
        a_vld    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (arm) begin
              wp    <= '0;
              cnt   <= '0;
              busy  <= 1'b1;
              state <= (PRE_TRIG == 0) ? ARMED : PRE;
            end
          end
          PRE: begin
            cnt <= cnt + 1'b1;
            if (cnt == PRE_LAST) state <= ARMED;
          end
          ARMED: begin
            if (trig) begin
              t_ptr <= wp;
              cnt   <= '0;
              if (POST_N == 0) begin
                state   <= READ;
                rp      <= wp - PRE_OFS;
                iss_cnt <= '0;
                a_vld   <= 1'b0;
              end else begin
                state <= POST;
              end
            end
          end
          POST: begin
            cnt <= cnt + 1'b1;
            if (cnt == POST_LAST) begin
              state   <= READ;
              rp      <= t_ptr - PRE_OFS;
              iss_cnt <= '0;
              a_vld   <= 1'b0;
            end
          end
          READ: begin
            if (re) begin
              rp      <= rp + 1'b1;
              iss_cnt <= iss_cnt + 1'b1;
              a_vld   <= 1'b1;
              a_last  <= (iss_cnt == LAST_WORD);
            end else if (move) begin
              a_vld <= 1'b0;
            end
            if (move) begin
              rd_valid <= 1'b1;
              rd_last  <= a_last;
              rd_data1 <= ram_q[DATA_W-1:0];
              rd_data2 <= ram_q[2*DATA_W-1:DATA_W];
`ifdef ADC_OTR_STORE_EN
              rd_otr1  <= ram_q[2*DATA_W];
              rd_otr2  <= ram_q[2*DATA_W+1];
`endif
            end else if (fire) begin
              rd_valid <= 1'b0;
              rd_last  <= 1'b0;
            end
            if (fire && rd_last) begin
              state    <= IDLE;
              busy     <= 1'b0;
              done     <= 1'b1;
              rd_valid <= 1'b0;
              rd_last  <= 1'b0;
              a_vld    <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dual_adc_capture.sv
// Bench for dual_adc_capture: table of capture scenarios checked against a sample-history model,
// plus abort/reset sequences. Honours ADC_OTR_STORE_EN for the expected OTR readout.
module tb_dual_adc_capture;

  localparam int DEPTH = 1024;
  localparam int PRE   = 256;
  localparam int POST  = DEPTH - PRE - 1;
  localparam int MAXN  = 8000;

  logic       clk_20M = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] ad_data1 = '0, ad_data2 = '0, trig_level = '0;
  logic       OTR1 = 1'b0, OTR2 = 1'b0, arm = 1'b0, abort = 1'b0, force_trig = 1'b0;
  logic       trig_ch = 1'b0, trig_edge = 1'b0, rd_ready = 1'b0;
  logic       busy, done, rd_valid, rd_last, rd_otr1, rd_otr2;
  logic [9:0] rd_data1, rd_data2;

  dual_adc_capture dut (
    .clk_20M(clk_20M), .rst_n(rst_n), .ad_data1(ad_data1), .ad_data2(ad_data2),
    .OTR1(OTR1), .OTR2(OTR2), .arm(arm), .abort(abort), .force_trig(force_trig),
    .trig_ch(trig_ch), .trig_edge(trig_edge), .trig_level(trig_level),
    .busy(busy), .done(done), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_last(rd_last),
    .rd_otr1(rd_otr1), .rd_otr2(rd_otr2)
  );

  always #25 clk_20M = ~clk_20M;

  typedef struct {
    int mode;   // 0 ramp, 1 step, 2 forced, 3 random
    bit ch;
    bit edg;
    int lvl;
    bit rnd;    // random rd_ready
    int chk;    // channel for the trigger-word checks
    int e256;   // expected word 256 on chk (-1: model only)
    int e255;
  } vec_t;

  vec_t vecs[7];
  int   checks = 0, errors = 0;
  // Sample history: index i = values present at the i-th rising edge after arm
  int   xd1[MAXN+2], xd2[MAXN+2];
  bit   xo1[MAXN+2], xo2[MAXN+2], xf[MAXN+2];

  task automatic check(input string name, input int tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0d, expected %0d", name, tag, act, exp);
    end
  endtask

  task automatic idle_inputs();
    arm = 0; abort = 0; force_trig = 0;
    ad_data1 = '0; ad_data2 = '0; OTR1 = 0; OTR2 = 0;
  endtask

  // Drive a capture from the arm edge until the first readout word appears (or abort_at)
  task automatic drive(input int mode, input int abort_at, output int first);
    first = -1;
    for (int i = 0; i < MAXN + 2; i++) begin
      xf[i] = 0; xo1[i] = 0; xo2[i] = 0; xd1[i] = 0; xd2[i] = 0;
    end
    for (int i = 0; i < MAXN && first == -1; i++) begin
      @(negedge clk_20M);
      case (mode)
        0: begin
          xd1[i] = i % DEPTH; xd2[i] = int'($urandom_range(0, 1023)); xo1[i] = (i == 500);
        end
        1: begin
          xd1[i] = int'($urandom_range(0, 1023)); xd2[i] = (i < 600) ? 800 : 100;
        end
        2: begin
          xd1[i] = int'($urandom_range(0, 600)); xd2[i] = int'($urandom_range(0, 1023));
          xf[i] = (i == 3428);
        end
        default: begin
          xd1[i] = int'($urandom_range(0, 1023)); xd2[i] = int'($urandom_range(0, 1023));
          xo1[i] = ($urandom_range(0, 15) == 0); xo2[i] = ($urandom_range(0, 15) == 0);
          xf[i] = (i == 2500);
        end
      endcase
      ad_data1 = 10'(xd1[i]); ad_data2 = 10'(xd2[i]);
      OTR1 = xo1[i]; OTR2 = xo2[i];
      arm = (i == 0); force_trig = xf[i]; abort = (i == abort_at);
      @(posedge clk_20M); #1;
      if (i == abort_at) first = -2;
      else if (rd_valid) first = i;
    end
    idle_inputs();
    if (abort_at < 0) check("trigger_seen", 0, int'(first >= 0), 1);
  endtask

  // Reference: first armed sample that crosses the level or carries a software trigger
  task automatic find_trig(input bit ch, input bit edg, input int lvl, input int first,
                           output int m);
    int p, c;
    m = -1;
    for (int k = PRE; k < first && m < 0; k++) begin
      p = ch ? xd2[k-1] : xd1[k-1];
      c = ch ? xd2[k] : xd1[k];
      if ((edg ? (p >= lvl && c < lvl) : (p < lvl && c >= lvl)) || xf[k+1]) m = k;
    end
  endtask

  task automatic collect(input int m, input bit rnd, input int nwords, input int chk,
                         input int e256, input int e255);
    int j, dones, idx, eo1, eo2;
    bit stalled, r;
    logic [23:0] held;
    j = 0; dones = 0; stalled = 0; held = '0;
    for (int cyc = 0; cyc < 8 * DEPTH && j < nwords; cyc++) begin
      @(negedge clk_20M);
      if (done) dones++;
      if (stalled)
        check("stall_hold", j, int'({rd_valid, rd_last, rd_otr2, rd_otr1, rd_data2, rd_data1}),
              int'(held));
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      rd_ready = r;
      stalled = 0;
      if (rd_valid && r) begin
        idx = m - PRE + j;
`ifdef ADC_OTR_STORE_EN
        eo1 = int'(xo1[idx]); eo2 = int'(xo2[idx]);
`else
        eo1 = 0; eo2 = 0;
`endif
        check("word_ch1", j, int'(rd_data1), xd1[idx]);
        check("word_ch2", j, int'(rd_data2), xd2[idx]);
        check("word_otr1", j, int'(rd_otr1), eo1);
        check("word_otr2", j, int'(rd_otr2), eo2);
        check("word_last", j, int'(rd_last), int'(j == DEPTH - 1));
        if (j == PRE && e256 >= 0)
          check("trig_word", j, int'(chk == 1 ? rd_data1 : rd_data2), e256);
        if (j == PRE - 1 && e255 >= 0)
          check("pre_trig_word", j, int'(chk == 1 ? rd_data1 : rd_data2), e255);
        j++;
      end else if (rd_valid) begin
        held = {1'b1, rd_last, rd_otr2, rd_otr1, rd_data2, rd_data1};
        stalled = 1;
      end
    end
    check("handshakes", nwords, j, nwords);
    if (nwords == DEPTH) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk_20M);
        rd_ready = 0;
        if (done) dones++;
      end
      check("done_pulses", 0, dones, 1);
      check("busy_after_read", 0, int'(busy), 0);
      check("valid_after_read", 0, int'(rd_valid), 0);
    end
  endtask

  task automatic start_capture(input vec_t v, input int abort_at, output int first, output int m);
    int lvl;
    bit ch, edg;
    lvl = v.lvl; ch = v.ch; edg = v.edg;
    if (v.mode == 3) begin
      lvl = int'($urandom_range(100, 900)); ch = 1'($urandom_range(0, 1));
      edg = 1'($urandom_range(0, 1));
    end
    trig_ch = ch; trig_edge = edg; trig_level = 10'(lvl);
    rd_ready = 0;
    drive(v.mode, abort_at, first);
    m = -1;
    if (first >= 0) begin
      find_trig(ch, edg, lvl, first, m);
      check("model_trigger", 0, int'(m >= 0), 1);
      if (m >= 0)
        check("first_valid_latency", first - m,
              int'((first - m - POST - 1) >= 1 && (first - m - POST - 1) <= 3), 1);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int first, m;
    start_capture(v, -1, first, m);
    if (m >= 0) collect(m, v.rnd, DEPTH, v.chk, v.e256, v.e255);
    else begin
      @(negedge clk_20M); abort = 1;
      @(negedge clk_20M); abort = 0;
    end
  endtask

  task automatic watch_no_done(input string name);
    int d;
    d = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_20M);
      if (done) d++;
    end
    check(name, 0, d, 0);
  endtask

  initial begin
    int first, m;
    vecs[0] = '{0, 1'b0, 1'b0, 500, 1'b0, 1, 500, 499};
    vecs[1] = '{0, 1'b0, 1'b0, 500, 1'b1, 1, 500, 499};
    vecs[2] = '{1, 1'b1, 1'b1, 300, 1'b0, 2, 100, 800};
    vecs[3] = '{2, 1'b0, 1'b0, 900, 1'b0, 1, -1, -1};
    vecs[4] = '{3, 1'b0, 1'b0, 0, 1'b0, 1, -1, -1};
    vecs[5] = '{3, 1'b0, 1'b0, 0, 1'b1, 1, -1, -1};
    vecs[6] = '{3, 1'b0, 1'b0, 0, 1'b1, 1, -1, -1};

    repeat (3) @(negedge clk_20M);
    check("reset_busy", 0, int'(busy), 0);
    check("reset_done", 0, int'(done), 0);
    check("reset_valid", 0, int'(rd_valid), 0);
    check("reset_last", 0, int'(rd_last), 0);
    check("reset_data", 0, int'({rd_otr2, rd_otr1, rd_data2, rd_data1}), 0);
    rst_n = 1;
    @(negedge clk_20M);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Abort in the middle of the post-trigger fill (trigger at sample 500)
    trig_ch = 0; trig_edge = 0; trig_level = 10'd500;
    drive(0, 700, first);
    check("abort_post_busy", 0, int'(busy), 0);
    check("abort_post_valid", 0, int'(rd_valid), 0);
    watch_no_done("abort_post_done");
    run_vec(vecs[0]);

    // Abort part-way through readout
    start_capture(vecs[0], -1, first, m);
    if (m >= 0) collect(m, 1'b0, 300, 1, 500, 499);
    @(negedge clk_20M); rd_ready = 0; abort = 1;
    @(posedge clk_20M); #1; abort = 0;
    check("abort_read_valid", 0, int'(rd_valid), 0);
    check("abort_read_last", 0, int'(rd_last), 0);
    check("abort_read_busy", 0, int'(busy), 0);
    watch_no_done("abort_read_done");
    run_vec(vecs[1]);

    // Reset part-way through readout
    start_capture(vecs[0], -1, first, m);
    if (m >= 0) collect(m, 1'b0, 600, 1, 500, 499);
    @(negedge clk_20M); rd_ready = 0; rst_n = 0;
    @(posedge clk_20M); #1;
    check("rst_read_busy", 0, int'(busy), 0);
    check("rst_read_valid", 0, int'(rd_valid), 0);
    check("rst_read_last", 0, int'(rd_last), 0);
    check("rst_read_data", 0, int'({rd_otr2, rd_otr1, rd_data2, rd_data1}), 0);
    @(negedge clk_20M); rst_n = 1;
    watch_no_done("rst_read_done");
    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #4500000;
    $display("FAIL watchdog: simulation exceeded its time budget, checks %0d errors %0d",
             checks, errors);
    $fatal(1);
  end

endmodule
